// File: rtl/dot_frame_buffer.sv
// dot_frame_buffer: double-buffered memory-mapped dot X/Y store with vblank-synchronised swap
// Ports:
//   clock, reset                single clock, synchronous active-high reset
//   wren, address, data         processor bus write/read request
//   q, hit                      registered read data and map-hit flag (1-cycle latency)
//   vblank                      one-cycle frame pulse; pending swaps take effect here
//   rd_id, rd_x, rd_y           display read of the front bank (1-cycle latency)
//   gen_count                   number of completed swaps
//   swap_pending, overrun, busy status flags
// Build option DOT_CLEAR_ON_SWAP_EN: after each swap, zero the new back bank one index per cycle.
module dot_frame_buffer #(
  parameter int NUM_DOTS  = 450,
  parameter int COORD_W   = 10,
  parameter int BASE_X    = 100,
  parameter int BASE_Y    = 550,
  parameter int CTRL_ADDR = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wren,
  input  logic [31:0]        address,
  input  logic [31:0]        data,
  output logic [31:0]        q,
  output logic               hit,
  input  logic               vblank,
  input  logic [15:0]        rd_id,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic [31:0]        gen_count,
  output logic               swap_pending,
  output logic               overrun,
  output logic               busy
);
  localparam int IDX_W = $clog2(NUM_DOTS);
  localparam logic [31:0] X_LO = 32'(BASE_X);
  localparam logic [31:0] X_HI = 32'(BASE_X + NUM_DOTS);
  localparam logic [31:0] Y_LO = 32'(BASE_Y);
  localparam logic [31:0] Y_HI = 32'(BASE_Y + NUM_DOTS);
  localparam logic [31:0] CTRL = 32'(CTRL_ADDR);
  logic front_sel;
  logic [COORD_W-1:0] mem_x [0:1][0:NUM_DOTS-1];
  logic [COORD_W-1:0] mem_y [0:1][0:NUM_DOTS-1];
  logic in_x, in_y, in_ctrl, ctrl_wr, dot_wr, drop, wr_ok, swap_now, rd_ok;
  logic [31:0] off_x, off_y, status;
  logic [IDX_W-1:0] idx_x, idx_y, rd_idx;
  logic unused_bits;
  always_comb begin
    in_x     = address >= X_LO && address < X_HI;
    in_y     = address >= Y_LO && address < Y_HI;
    in_ctrl  = address == CTRL;
    off_x    = address - X_LO;
    off_y    = address - Y_LO;
    idx_x    = off_x[IDX_W-1:0];
    idx_y    = off_y[IDX_W-1:0];
    rd_idx   = rd_id[IDX_W-1:0];
    rd_ok    = rd_id < 16'(NUM_DOTS);
    ctrl_wr  = wren && in_ctrl;
    swap_now = vblank && swap_pending && !busy;
    dot_wr   = wren && (in_x || in_y);
    // A write landing in the swap cycle still targets the old back bank, so it is kept.
    drop     = dot_wr && ((swap_pending && !swap_now) || busy);
    wr_ok    = dot_wr && !drop && !reset;
    status   = {gen_count[15:0], 12'b0, busy, overrun, swap_pending, front_sel};
  end
  assign unused_bits = ^{data[31:COORD_W], off_x[31:IDX_W], off_y[31:IDX_W], rd_id[15:IDX_W]};
`ifdef DOT_CLEAR_ON_SWAP_EN
  logic [IDX_W-1:0] clr_idx;
  always_ff @(posedge clock) begin
    if (reset) begin
      busy    <= 1'b0;
      clr_idx <= '0;
    end else if (swap_now) begin
      busy    <= 1'b1;
      clr_idx <= '0;
    end else if (busy) begin
      clr_idx <= clr_idx + 1'b1;
      busy    <= clr_idx != IDX_W'(NUM_DOTS - 1);
    end
  end
`else
  assign busy = 1'b0;
`endif
  // Banks are not reset; the back bank is always ~front_sel (the new back bank while clearing).
  always_ff @(posedge clock) begin
    if (wr_ok && in_x) mem_x[~front_sel][idx_x] <= data[COORD_W-1:0];
    if (wr_ok && in_y) mem_y[~front_sel][idx_y] <= data[COORD_W-1:0];
`ifdef DOT_CLEAR_ON_SWAP_EN
    if (busy && !reset) begin
      mem_x[~front_sel][clr_idx] <= '0;
      mem_y[~front_sel][clr_idx] <= '0;
    end
`endif
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      front_sel    <= 1'b0;
      gen_count    <= '0;
      swap_pending <= 1'b0;
      overrun      <= 1'b0;
      q            <= '0;
      hit          <= 1'b0;
      rd_x         <= '0;
      rd_y         <= '0;
    end else begin
      front_sel    <= front_sel ^ swap_now;
      gen_count    <= gen_count + 32'(swap_now);
      swap_pending <= swap_now ? 1'b0 : swap_pending || (ctrl_wr && data[0]);
      overrun      <= (overrun && !(ctrl_wr && data[1])) || drop;
      hit          <= in_x || in_y || in_ctrl;
      q            <= wren ? '0 :
                      in_x ? 32'(mem_x[~front_sel][idx_x]) :
                      in_y ? 32'(mem_y[~front_sel][idx_y]) :
                      in_ctrl ? status : '0;
      rd_x         <= rd_ok ? mem_x[front_sel][rd_idx] : '0;
      rd_y         <= rd_ok ? mem_y[front_sel][rd_idx] : '0;
    end
  end
endmodule
